// File: rtl/move_applier_pkg.sv
// Shared encodings for the piece table and the 16-bit move word.
// No logic; types, codes and a slot-occupancy helper.
// Optional check feature is controlled by MOVE_APPLIER_CHECK_EN in move_applier.sv.
package move_applier_pkg;

  // Piece type codes (piece bits 9:7)
  typedef enum logic [2:0] {
    P_EMPTY   = 3'd0,
    P_PAWN    = 3'd1,
    P_KNIGHT  = 3'd2,
    P_BISHOP  = 3'd3,
    P_ROOK    = 3'd4,
    P_QUEEN   = 3'd5,
    P_KING    = 3'd6,
    P_INVALID = 3'd7
  } ptype_e;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  // Piece entry: type 9:7, col 6:4, row 3:1, color 0
  typedef struct packed {
    logic [2:0] ptype;
    logic [2:0] col;
    logic [2:0] row;
    logic       color;
  } piece_t;

  // Move word bits 13:0: promo 13, capture 12, src 11:6, dest 5:0
  typedef struct packed {
    logic       promo;
    logic       capture;
    logic [2:0] src_col;
    logic [2:0] src_row;
    logic [2:0] dst_col;
    logic [2:0] dst_row;
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // A slot takes part in square matching only if it holds a real piece
  function automatic logic occupied(input piece_t p);
    return (p.ptype != P_EMPTY) && (p.ptype != P_INVALID);
  endfunction

endpackage

// File: rtl/move_applier_piece_table.sv
// Piece table: SLOTS x 10-bit register file, async reset to EMPTY.
// One synchronous write port plus a capture-clear port (type field only);
// the full write wins when both hit one slot. Two combinational read ports.
module move_applier_piece_table
  import move_applier_pkg::*;
#(
  parameter int SLOTS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [$clog2(SLOTS)-1:0]   wr_idx_i,
  input  logic [9:0]                 wr_piece_i,
  input  logic                       clr_en_i,
  input  logic [$clog2(SLOTS)-1:0]   clr_idx_i,
  input  logic [$clog2(SLOTS)-1:0]   scan_idx_i,
  output logic [9:0]                 scan_piece_o,
  input  logic [$clog2(SLOTS)-1:0]   rd_idx_i,
  output logic [9:0]                 rd_piece_o
);

  logic [9:0] mem_q [SLOTS];

  // Storage update: clear captured piece's type, then full write (later wins)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
    end else begin
      if (clr_en_i) mem_q[clr_idx_i][9:7] <= P_EMPTY;
      if (wr_en_i)  mem_q[wr_idx_i]       <= wr_piece_i;
    end
  end

  assign scan_piece_o = mem_q[scan_idx_i];
  assign rd_piece_o   = mem_q[rd_idx_i];

endmodule

// File: rtl/move_applier.sv
// Move applier: takes a move, scans all slots one per cycle, then commits or rejects.
// Latency: handshake N, scan N+1..N+SLOTS, done/error in N+SLOTS+1; ready again N+SLOTS+2.
// Optional MOVE_APPLIER_CHECK_EN enables color/capture/dup/promo legality; otherwise only src_hit.
module move_applier
  import move_applier_pkg::*;
#(
  parameter int SLOTS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [15:0]                move,
  output logic                       done,
  output logic                       error,
  output logic                       turn,
  input  logic                       wr_en,
  input  logic [$clog2(SLOTS)-1:0]   wr_idx,
  input  logic [9:0]                 wr_piece,
  input  logic [$clog2(SLOTS)-1:0]   rd_idx,
  output logic [9:0]                 rd_piece
);

  localparam int IW = $clog2(SLOTS);

`ifdef MOVE_APPLIER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_e        state_q;
  move_t         move_q;
  logic [IW-1:0] cnt_q;
  logic          src_hit_q, dst_hit_q, dup_q;
  logic [IW-1:0] src_idx_q, dst_idx_q;
  logic [2:0]    src_type_q;
  logic          src_color_q, dst_color_q;
  logic          ok_q, done_q, error_q, ready_q, turn_q;

  logic          src_hit_d, dst_hit_d, dup_d;
  logic [IW-1:0] src_idx_d, dst_idx_d;
  logic [2:0]    src_type_d;
  logic          src_color_d, dst_color_d;
  logic          legal_d, ok_d;

  piece_t        scan_piece;
  logic [9:0]    scan_raw;
  logic          tbl_wr_en, tbl_clr_en;
  logic [IW-1:0] tbl_wr_idx;
  piece_t        tbl_wr_piece;

  // Upper move bits are reserved and carry no information
  logic unused_move_bits;
  assign unused_move_bits = ^move[15:14];

  assign scan_piece = scan_raw;

  // Fold the slot under the scan counter into the hit/dup bookkeeping and judge the move
  always_comb begin
    src_hit_d   = src_hit_q;
    dst_hit_d   = dst_hit_q;
    dup_d       = dup_q;
    src_idx_d   = src_idx_q;
    dst_idx_d   = dst_idx_q;
    src_type_d  = src_type_q;
    src_color_d = src_color_q;
    dst_color_d = dst_color_q;
    if (occupied(scan_piece)) begin
      if (scan_piece.col == move_q.src_col && scan_piece.row == move_q.src_row) begin
        if (src_hit_q) begin
          dup_d = 1'b1;
        end else begin
          src_hit_d   = 1'b1;
          src_idx_d   = cnt_q;
          src_type_d  = scan_piece.ptype;
          src_color_d = scan_piece.color;
        end
      end
      if (scan_piece.col == move_q.dst_col && scan_piece.row == move_q.dst_row) begin
        if (dst_hit_q) begin
          dup_d = 1'b1;
        end else begin
          dst_hit_d   = 1'b1;
          dst_idx_d   = cnt_q;
          dst_color_d = scan_piece.color;
        end
      end
    end
    legal_d = (src_color_d == turn_q) && !dup_d;
    if (move_q.capture) legal_d = legal_d && dst_hit_d && (dst_color_d != turn_q);
    else                legal_d = legal_d && !dst_hit_d;
    if (move_q.promo)
      legal_d = legal_d && (src_type_d == P_PAWN) &&
                (move_q.dst_row == ((turn_q == WHITE) ? 3'd7 : 3'd0));
    ok_d = src_hit_d && (legal_d || !CHECK_EN);
  end

  // Table write steering: external loads in IDLE, move update in COMMIT
  always_comb begin
    tbl_wr_en    = 1'b0;
    tbl_clr_en   = 1'b0;
    tbl_wr_idx   = wr_idx;
    tbl_wr_piece = wr_piece;
    if (state_q == ST_IDLE) begin
      tbl_wr_en = wr_en;
    end else if (state_q == ST_COMMIT && ok_q) begin
      tbl_wr_en          = 1'b1;
      tbl_wr_idx         = src_idx_q;
      tbl_wr_piece.ptype = move_q.promo ? P_QUEEN : src_type_q;
      tbl_wr_piece.col   = move_q.dst_col;
      tbl_wr_piece.row   = move_q.dst_row;
      tbl_wr_piece.color = src_color_q;
      tbl_clr_en         = move_q.capture && dst_hit_q;
    end
  end

  // Control FSM with registered ready/done/error/turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      move_q      <= '0;
      cnt_q       <= '0;
      src_hit_q   <= 1'b0;
      dst_hit_q   <= 1'b0;
      dup_q       <= 1'b0;
      src_idx_q   <= '0;
      dst_idx_q   <= '0;
      src_type_q  <= '0;
      src_color_q <= 1'b0;
      dst_color_q <= 1'b0;
      ok_q        <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b1;
      turn_q      <= WHITE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (move_valid && ready_q) begin
            move_q    <= move[13:0];
            cnt_q     <= '0;
            src_hit_q <= 1'b0;
            dst_hit_q <= 1'b0;
            dup_q     <= 1'b0;
            src_idx_q <= '0;
            dst_idx_q <= '0;
            ready_q   <= 1'b0;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          src_hit_q   <= src_hit_d;
          dst_hit_q   <= dst_hit_d;
          dup_q       <= dup_d;
          src_idx_q   <= src_idx_d;
          dst_idx_q   <= dst_idx_d;
          src_type_q  <= src_type_d;
          src_color_q <= src_color_d;
          dst_color_q <= dst_color_d;
          // Last slot: stop on all-ones instead of wrapping, verdict goes out in COMMIT
          if (cnt_q == '1) begin
            ok_q    <= ok_d;
            done_q  <= ok_d;
            error_q <= !ok_d;
            state_q <= ST_COMMIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          if (ok_q) turn_q <= ~turn_q;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  move_applier_piece_table #(.SLOTS(SLOTS)) u_table (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (tbl_wr_en),
    .wr_idx_i     (tbl_wr_idx),
    .wr_piece_i   (tbl_wr_piece),
    .clr_en_i     (tbl_clr_en),
    .clr_idx_i    (dst_idx_q),
    .scan_idx_i   (cnt_q),
    .scan_piece_o (scan_raw),
    .rd_idx_i     (rd_idx),
    .rd_piece_o   (rd_piece)
  );

  assign move_ready = ready_q;
  assign done       = done_q;
  assign error      = error_q;
  assign turn       = turn_q;

endmodule

// File: tb/tb_move_applier.sv
// Bench for move_applier: directed scenarios plus random moves, scoreboarded against a table model.
module tb_move_applier;

  localparam int SLOTS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_valid;
  logic        move_ready;
  logic [15:0] move;
  logic        done, error, turn;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [9:0]  wr_piece;
  logic [4:0]  rd_idx;
  logic [9:0]  rd_piece;

  move_applier #(.SLOTS(SLOTS)) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_ready(move_ready), .move(move),
    .done(done), .error(error), .turn(turn), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_piece(wr_piece), .rd_idx(rd_idx), .rd_piece(rd_piece)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int miscompares = 0;

  // Reference: plain array of pieces plus side to move
  logic [9:0] model [SLOTS];
  bit         mturn;

  typedef struct { bit ok; int at; } exp_t;
  exp_t sb[$];

  localparam int T_EMPTY = 0, T_PAWN = 1, T_KNIGHT = 2, T_QUEEN = 5, T_INVALID = 7;

  function automatic logic [9:0] pc(input int t, input int c, input int r, input int color);
    logic [9:0] p;
    p = {t[2:0], c[2:0], r[2:0], color[0]};
    return p;
  endfunction

  function automatic logic [15:0] mv(input int promo, input int cap, input int sc, input int sr,
                                     input int dc, input int dr);
    logic [15:0] m;
    m = {2'b00, promo[0], cap[0], sc[2:0], sr[2:0], dc[2:0], dr[2:0]};
    return m;
  endfunction

  function automatic bit real_piece(input logic [9:0] p);
    return p[9:7] != 3'(T_EMPTY) && p[9:7] != 3'(T_INVALID);
  endfunction

  // Apply a move to the model by the rules of the game table; returns accept/reject
  function automatic bit model_apply(input logic [15:0] m);
    int sc = 0, dc = 0, si = 0, di = 0;
    bit ok;
    bit promo, cap;
    logic [2:0] scol, srow, dcol, drow;
    logic [9:0] sp;
    promo = m[13]; cap = m[12];
    scol = m[11:9]; srow = m[8:6]; dcol = m[5:3]; drow = m[2:0];
    for (int i = 0; i < SLOTS; i++) begin
      if (real_piece(model[i])) begin
        if (model[i][6:4] == scol && model[i][3:1] == srow) begin
          if (sc == 0) si = i;
          sc++;
        end
        if (model[i][6:4] == dcol && model[i][3:1] == drow) begin
          if (dc == 0) di = i;
          dc++;
        end
      end
    end
    sp = model[si];
`ifdef MOVE_APPLIER_CHECK_EN
    ok = (sc > 0) && (sp[0] == mturn) && (sc < 2) && (dc < 2) &&
         (cap ? (dc > 0 && model[di][0] != mturn) : (dc == 0)) &&
         (!promo || (sp[9:7] == 3'(T_PAWN) && drow == (mturn ? 3'd0 : 3'd7)));
`else
    ok = (sc > 0);
`endif
    if (ok) begin
      if (cap && dc > 0) model[di][9:7] = 3'(T_EMPTY);
      model[si] = {promo ? 3'(T_QUEEN) : sp[9:7], dcol, drow, sp[0]};
      mturn = ~mturn;
    end
    return ok;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/error pulse must match the oldest expectation in outcome and cycle
  always @(negedge clk) begin
    if (!rst && (done || error)) begin
      vecs++;
      if (done && error) begin
        miscompares++;
        $display("FAIL both_pulses: done=%0b error=%0b cycle=%0d", done, error, cyc);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b cycle=%0d, none expected", done, error, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done != e.ok || cyc != e.at) begin
          miscompares++;
          $display("FAIL outcome: done=%0b at cycle %0d, expected done=%0b at cycle %0d",
                   done, cyc, e.ok, e.at);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SLOTS; i++) model[i] = '0;
    mturn = 1'b0;
    sb.delete();
  endtask

  task automatic load(input int idx, input logic [9:0] p);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx[4:0]; wr_piece = p;
    @(negedge clk);
    wr_en = 1'b0;
    model[idx] = p;
  endtask

  // Offer a move and hold valid until it is taken; n is the handshake cycle
  task automatic issue(input logic [15:0] m, input bit push, output int n);
    bit ok;
    bit taken = 0;
    @(negedge clk);
    move = m; move_valid = 1'b1;
    n = -1;
    for (int k = 0; k < 100; k++) begin
      if (move_ready) begin taken = 1; break; end
      @(negedge clk);
    end
    if (!taken) begin
      vecs++; miscompares++;
      $display("FAIL handshake_timeout: move_ready=%0b expected 1", move_ready);
    end else begin
      n = cyc;
      if (push) begin
        ok = model_apply(m);
        sb.push_back('{ok, n + 33});
      end
    end
  endtask

  task automatic drop();
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit empty = 0;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) begin empty = 1; break; end
      @(negedge clk);
    end
    if (!empty) begin
      vecs++; miscompares++;
      $display("FAIL response_timeout: %0d outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_turn"}, 32'(turn), 32'(mturn));
    chk({tag, "_ready"}, 32'(move_ready), 32'd1);
    for (int i = 0; i < SLOTS; i++) begin
      rd_idx = i[4:0];
      #1;
      chk($sformatf("%s_slot%0d", tag, i), 32'(rd_piece), 32'(model[i]));
    end
  endtask

  task automatic run_move(input logic [15:0] m, input string tag);
    int n;
    issue(m, 1'b1, n);
    drop();
    wait_idle();
    check_state(tag);
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2;
    rst = 1'b1; move_valid = 1'b0; move = '0; wr_en = 1'b0; wr_idx = '0; wr_piece = '0; rd_idx = '0;
    for (int i = 0; i < SLOTS; i++) model[i] = '0;
    mturn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");

    // Quiet knight move
    load(3, pc(T_KNIGHT, 1, 0, 0));
    run_move(mv(0, 0, 1, 0, 2, 2), "quiet");

    // Capture of a black pawn
    do_reset();
    load(3, pc(T_KNIGHT, 1, 0, 0));
    load(20, pc(T_PAWN, 2, 2, 1));
    run_move(mv(0, 1, 1, 0, 2, 2), "capture");

    // Non-capture onto an occupied square
    do_reset();
    load(3, pc(T_KNIGHT, 1, 0, 0));
    load(20, pc(T_PAWN, 2, 2, 1));
    run_move(mv(0, 0, 1, 0, 2, 2), "quiet_onto_piece");

    // Wrong side to move
    do_reset();
    load(5, pc(T_PAWN, 3, 6, 1));
    run_move(mv(0, 0, 3, 6, 3, 5), "wrong_color");

    // Promotion and illegal promotion
    do_reset();
    load(7, pc(T_PAWN, 4, 6, 0));
    run_move(mv(1, 0, 4, 6, 4, 7), "promo");
    do_reset();
    load(9, pc(T_KNIGHT, 1, 5, 0));
    run_move(mv(1, 0, 1, 5, 2, 7), "promo_knight");

    // Empty source square and duplicated source
    do_reset();
    run_move(mv(0, 0, 0, 0, 0, 1), "no_src");
    load(2, pc(T_PAWN, 0, 1, 0));
    load(31, pc(T_PAWN, 0, 1, 0));
    run_move(mv(0, 0, 0, 1, 0, 2), "dup_src");

    // Back-to-back moves with move_valid held high
    do_reset();
    load(3, pc(T_KNIGHT, 1, 0, 0));
    load(10, pc(T_PAWN, 6, 6, 1));
    issue(mv(0, 0, 1, 0, 2, 2), 1'b1, n1);
    issue(mv(0, 0, 6, 6, 6, 5), 1'b1, n2);
    chk("b2b_accept_cycle", 32'(n2), 32'(n1 + 34));
    drop();
    wait_idle();
    check_state("b2b");

    // Table load during a scan is ignored
    do_reset();
    load(3, pc(T_KNIGHT, 1, 0, 0));
    issue(mv(0, 0, 1, 0, 2, 2), 1'b1, n1);
    drop();
    repeat (5) @(negedge clk);
    wr_en = 1'b1; wr_idx = 5'd30; wr_piece = pc(T_QUEEN, 7, 7, 1);
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle();
    check_state("wr_midscan");

    // Reset in the middle of a scan aborts the move
    do_reset();
    load(3, pc(T_KNIGHT, 1, 0, 0));
    mturn = 1'b0;
    issue(mv(0, 0, 1, 0, 2, 2), 1'b0, n1);
    drop();
    for (int k = 0; k < 100 && cyc < n1 + 10; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SLOTS; i++) model[i] = '0;
    mturn = 1'b0;
    repeat (40) @(negedge clk);
    check_state("rst_midscan");

    // Random positions and moves
    do_reset();
    for (int i = 0; i < 12; i++)
      load($urandom_range(0, SLOTS - 1),
           pc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1)));
    for (int t = 0; t < 30; t++) begin
      int sidx, sc, sr, dc, dr, cap, promo;
      if ($urandom_range(0, 3) == 0)
        load($urandom_range(0, SLOTS - 1),
             pc($urandom_range(1, 6), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1)));
      sidx = $urandom_range(0, SLOTS - 1);
      for (int k = 0; k < SLOTS; k++) begin
        int j;
        j = (sidx + k) % SLOTS;
        if (real_piece(model[j]) && model[j][0] == mturn) begin sidx = j; break; end
      end
      sc = int'(model[sidx][6:4]);
      sr = int'(model[sidx][3:1]);
      if ($urandom_range(0, 4) == 0) begin sc = $urandom_range(0, 7); sr = $urandom_range(0, 7); end
      dc = $urandom_range(0, 7);
      dr = $urandom_range(0, 7);
      cap = 0;
      for (int k = 0; k < SLOTS; k++)
        if (real_piece(model[k]) && model[k][6:4] == dc[2:0] && model[k][3:1] == dr[2:0]) cap = 1;
      if ($urandom_range(0, 5) == 0) cap = 1 - cap;
      promo = ($urandom_range(0, 7) == 0) ? 1 : 0;
      run_move(mv(promo, cap, sc, sr, dc, dr), $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
